instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage of the RV64 core: owns the program counter, fetches 32-bit instruction words from instruction memory over a req/valid handshake, and presents each word with its PC to the decode stage, where the immediate generator and control unit consume it. Accepts redirects (branch/JAL/JALR targets computed downstream from the extended immediate), flushing in-flight fetches, and halts on a misaligned target.

## Interface
- RESET_PC, default 64'h0: PC of the first fetch after reset.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset.
- imem_req  out  1  fetch request; high in FETCH and KILL.
- imem_addr  out  64  fetch address; equals pc register; stable while imem_req high.
- imem_valid  in  1  completes the transaction in any cycle where imem_req && imem_valid; ignored when imem_req low.
- imem_rdata  in  32  instruction word; sampled only on completion.
- inst  out  32  held instruction word, to decode / immediate generator.
- inst_pc  out  64  PC of inst.
- inst_valid  out  1  inst/inst_pc are valid (state HOLD).
- inst_ready  in  1  decode accepts inst this cycle.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  64  new fetch target.
- fetch_fault  out  1  misaligned redirect target; sticky until reset.

## Operation
- States: FETCH, HOLD, KILL, FAULT. Reset state FETCH.
- Registers: pc (64), tgt (64, pending redirect target), inst (32), inst_pc (64).
- FETCH: imem_req=1, imem_addr=pc. On completion: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, go HOLD. redirect without completion: tgt<=redirect_pc, go KILL (address may not change mid-transaction). redirect with completion same cycle: data discarded, pc<=redirect_pc, stay FETCH.
- HOLD: inst_valid=1, imem_req=0. redirect (priority over inst_ready): pc<=redirect_pc, go FETCH, inst dropped. Else inst_ready: go FETCH. Else hold all outputs stable.
- KILL: imem_req=1, imem_addr unchanged. Further redirect overwrites tgt (latest wins). On completion: data discarded, pc<=tgt (or redirect_pc if redirect in same cycle), go FETCH.
- Misalignment: any accepted redirect with redirect_pc[1:0]!=2'b00 goes to FAULT instead of its normal target, except in KILL: stay in KILL until completion, then FAULT. FAULT: imem_req=0, inst_valid=0, fetch_fault=1; only reset exits.
- Arithmetic: pc+4 modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- inst holds last accepted word outside HOLD; consumers qualify with inst_valid.

## Timing
- Reset values: pc=RESET_PC, tgt=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, inst_valid=0, fetch_fault=0, imem_req=0 while reset high.
- First request: imem_req=1 in the first cycle after reset deasserts.
- All outputs are decoded from state/registers; none is combinational from inputs.
- Latency: completion in cycle N puts inst_valid=1 in cycle N+1.
- Throughput, zero-wait memory (valid same cycle as req) and inst_ready tied high: one instruction per 2 cycles (FETCH, HOLD).
- Redirect in HOLD at cycle N: inst_valid=0 and imem_addr=redirect_pc at N+1.
- Reset mid-transaction: immediate return to reset values; a late imem_valid after reset is a new completion only if imem_req is high.

## Structure
- Shared package proc_pkg: XLEN=64, INST_W=32, NOP_INST=32'h0000_0013, fetch_state_t enum {FETCH, HOLD, KILL, FAULT}. The same package serves the immediate generator and decode.
- Single module, no sub-module: one state register process, one next-state/datapath combinational process.

## Test plan
- Reset, RESET_PC=64'h100, zero-wait memory, inst_ready=1 -> addresses 0x100, 0x104, 0x108 issued; inst_valid every 2nd cycle with matching inst_pc.
- Memory with 3-cycle wait, redirect to 0x200 one cycle after request to 0x104 -> imem_addr stays 0x104 until valid, data never reaches inst_valid, next request 0x200.
- HOLD with inst_ready=0 for 5 cycles -> inst, inst_pc stable; then redirect and inst_ready together to 0x40 -> inst dropped, next imem_addr 0x40.
- Two redirects in KILL (0x300 then 0x400) -> after completion, next fetch at 0x400.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetch completes -> next imem_addr 0.
- Redirect to 0x202 in HOLD -> FAULT: fetch_fault=1, imem_req=0, inst_valid=0 until reset; after reset, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the RV64 front end. The fetch unit, the
// immediate generator and decode all use these.
//   XLEN     - architectural register / address width
//   INST_W   - instruction word width
//   NOP_INST - canonical NOP (addi x0, x0, 0), shown by decode while idle
//   fetch_state_t - fetch controller states
package proc_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // Instruction fetch targets must be word aligned. Only the two low
  // address bits take part in the test.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the RV64 core.
// Owns the PC. Fetches one 32-bit word at a time over a req/valid handshake
// and holds it, with its PC, for decode. A redirect flushes the current fetch.
// A misaligned redirect target stops the unit permanently, until reset.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   reset        in   asynchronous, active-high reset
//   imem_req     out  fetch request; high while a transaction is open
//   imem_addr    out  fetch address (the pc register)
//   imem_valid   in   completes the transaction when imem_req is high
//   imem_rdata   in   instruction word, sampled on completion
//   inst         out  held instruction word
//   inst_pc      out  PC of inst
//   inst_valid   out  inst / inst_pc are valid for decode
//   inst_ready   in   decode takes inst this cycle
//   redirect     in   flush and restart fetch at redirect_pc
//   redirect_pc  in   new fetch target
//   fetch_fault  out  sticky: a misaligned redirect target was taken
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              fetch_fault
);

  fetch_state_t      state, state_next;
  logic [XLEN-1:0]   pc, pc_next;
  logic [XLEN-1:0]   tgt, tgt_next;
  logic [INST_W-1:0] inst_next;
  logic [XLEN-1:0]   inst_pc_next;
  logic [XLEN-1:0]   kill_dest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      tgt     <= '0;
      inst    <= NOP_INST;
      inst_pc <= RESET_PC;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      tgt     <= tgt_next;
      inst    <= inst_next;
      inst_pc <= inst_pc_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    tgt_next     = tgt;
    inst_next    = inst;
    inst_pc_next = inst_pc;
    // In KILL, a redirect in the same cycle as completion overrides the
    // stored target. The latest redirect wins.
    kill_dest    = redirect ? redirect_pc : tgt;

    case (state)
      FETCH: begin
        if (redirect) begin
          if (imem_valid) begin
            // The word arriving now belongs to the old path, so drop it.
            if (is_aligned(redirect_pc[1:0])) begin
              pc_next = redirect_pc;
            end else begin
              state_next = FAULT;
            end
          end else begin
            // imem_addr must not change mid-transaction. Keep the target
            // and let the open request drain in KILL.
            tgt_next   = redirect_pc;
            state_next = KILL;
          end
        end else if (imem_valid) begin
          inst_next    = imem_rdata;
          inst_pc_next = pc;
          pc_next      = pc + XLEN'(4);
          state_next   = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          if (is_aligned(redirect_pc[1:0])) begin
            pc_next    = redirect_pc;
            state_next = FETCH;
          end else begin
            state_next = FAULT;
          end
        end else if (inst_ready) begin
          state_next = FETCH;
        end
      end

      KILL: begin
        if (redirect) begin
          tgt_next = redirect_pc;
        end
        if (imem_valid) begin
          // The target is checked for alignment only once the flushed
          // transaction has finished on the bus.
          if (is_aligned(kill_dest[1:0])) begin
            pc_next    = kill_dest;
            state_next = FETCH;
          end else begin
            state_next = FAULT;
          end
        end
      end

      FAULT: begin
        state_next = FAULT;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // The request is gated by reset so that imem_req is low while reset is
  // held, even though the reset state is FETCH.
  assign imem_req    = !reset && ((state == FETCH) || (state == KILL));
  assign imem_addr   = pc;
  assign inst_valid  = (state == HOLD);
  assign fetch_fault = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed stimulus for instr_fetch_unit.
// A transaction-level reference model predicts the bus activity and the
// words delivered to decode. Delivered words go into a scoreboard queue that
// a negedge monitor checks against the DUT outputs.
module tb_instr_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        fetch_fault;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A00_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, described in terms of transactions:
  //   m_busy   - a memory request should be open, at address m_addr
  //   m_doomed - the open request was overtaken by a redirect and its data
  //              is thrown away; afterwards fetch resumes at m_after
  //   m_have   - a word is being offered to decode
  //   m_dead   - a misaligned target was taken
  logic [63:0] m_addr, m_after;
  bit          m_busy, m_doomed, m_have, m_dead;
  logic [95:0] sb[$];

  // Inputs applied for the current cycle, used by the model at the next edge.
  bit          cur_v, cur_rdy, cur_rd;
  logic [63:0] cur_rpc;

  task automatic model_reset();
    m_addr = RST_PC; m_after = '0;
    m_busy = 1'b1; m_doomed = 1'b0; m_have = 1'b0; m_dead = 1'b0;
    sb.delete();
  endtask

  task automatic go_to(input logic [63:0] t);
    if (t[1:0] != 2'b00) begin
      m_dead = 1'b1; m_busy = 1'b0; m_doomed = 1'b0; m_have = 1'b0;
    end else begin
      m_addr = t; m_busy = 1'b1;
    end
  endtask

  task automatic model_step(input bit v, input bit rdy, input bit rd, input logic [63:0] rpc);
    if (m_dead) return;
    if (m_busy) begin
      if (m_doomed) begin
        if (rd) m_after = rpc;
        if (v) begin
          m_doomed = 1'b0;
          go_to(m_after);
        end
      end else if (rd && !v) begin
        m_doomed = 1'b1;
        m_after  = rpc;
      end else if (rd) begin
        go_to(rpc);
      end else if (v) begin
        sb.push_back({mem_word(m_addr), m_addr});
        m_have = 1'b1;
        m_busy = 1'b0;
        m_addr = m_addr + 64'd4;
      end
    end else if (m_have) begin
      if (rd) begin
        m_have = 1'b0;
        go_to(rpc);
      end else if (rdy) begin
        m_have = 1'b0;
        m_busy = 1'b1;
      end
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("imem_req", 64'(imem_req), 64'(m_busy));
      if (m_busy) chk("imem_addr", imem_addr, m_addr);
      chk("fetch_fault", 64'(fetch_fault), 64'(m_dead));
      chk("inst_valid", 64'(inst_valid), 64'(m_have));
      if (inst_valid) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'(0), 64'(1));
        end else begin
          chk("inst", 64'(inst), 64'(sb[0][95:64]));
          chk("inst_pc", inst_pc, sb[0][63:0]);
          if (inst_ready || redirect) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick(input bit v, input bit rdy, input bit rd, input logic [63:0] rpc);
    @(posedge clk);
    if (!reset) model_step(cur_v, cur_rdy, cur_rd, cur_rpc);
    #1;
    cur_v = v; cur_rdy = rdy; cur_rd = rd; cur_rpc = rpc;
    imem_valid = v; inst_ready = rdy; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cur_v = 1'b0; cur_rdy = 1'b0; cur_rd = 1'b0; cur_rpc = '0;
    imem_valid = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    model_reset();
    @(negedge clk);
    chk("rst_imem_req", 64'(imem_req), 64'(0));
    chk("rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("rst_fetch_fault", 64'(fetch_fault), 64'(0));
    chk("rst_inst", 64'(inst), 64'(NOP));
    chk("rst_inst_pc", inst_pc, RST_PC);
    chk("rst_imem_addr", imem_addr, RST_PC);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    imem_valid = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cur_v = 1'b0; cur_rdy = 1'b0; cur_rd = 1'b0; cur_rpc = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Zero-wait memory, decode always ready: sequential stream from 0x100.
    do_reset();
    repeat (10) tick(1'b1, 1'b1, 1'b0, 64'h0);

    // Wait states, redirect while the fetch of 0x104 is outstanding.
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    tick(1'b0, 1'b1, 1'b0, 64'h0);
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    tick(1'b0, 1'b0, 1'b1, 64'h200);
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    tick(1'b1, 1'b0, 1'b0, 64'h0);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    tick(1'b0, 1'b1, 1'b0, 64'h0);

    // Decode stalls for 5 cycles, then redirect together with ready.
    tick(1'b1, 1'b0, 1'b0, 64'h0);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 64'h0);
    tick(1'b0, 1'b1, 1'b1, 64'h40);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    tick(1'b0, 1'b1, 1'b0, 64'h0);

    // Two redirects while a flushed fetch drains: the later one wins.
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    tick(1'b0, 1'b0, 1'b1, 64'h300);
    tick(1'b0, 1'b0, 1'b1, 64'h400);
    tick(1'b1, 1'b0, 1'b0, 64'h0);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    tick(1'b0, 1'b1, 1'b0, 64'h0);

    // PC wrap from the last word of the address space.
    tick(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    tick(1'b0, 1'b1, 1'b0, 64'h0);
    tick(1'b1, 1'b1, 1'b0, 64'h0);
    tick(1'b0, 1'b1, 1'b0, 64'h0);

    // Misaligned redirect from HOLD, then recovery through reset.
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 64'h0);
    tick(1'b0, 1'b0, 1'b1, 64'h202);
    tick(1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    chk("fault_set", 64'(fetch_fault), 64'(1));
    chk("fault_no_req", 64'(imem_req), 64'(0));
    chk("fault_no_valid", 64'(inst_valid), 64'(0));
    repeat (4) tick(1'b1, 1'b1, 1'b1, 64'h500);
    do_reset();
    repeat (6) tick(1'b1, 1'b1, 1'b0, 64'h0);

    // Randomized traffic, with occasional resets and misaligned targets.
    for (int i = 0; i < 3000; i++) begin
      bit          v, r, d;
      logic [63:0] t;
      v = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 11) == 0);
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) t[63:8] = '1;
      t[1:0] = ($urandom_range(0, 29) == 0) ? 2'b10 : 2'b00;
      tick(v, r, d, t);
      if (m_dead && ($urandom_range(0, 3) == 0)) do_reset();
      else if ($urandom_range(0, 599) == 0) do_reset();
    end

    tick(1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
